// File: rtl/vga_scroll_sequencer.sv
// vga_scroll_sequencer: frame-rate controller for the VGA pattern datapath.
// Detects vsync rising edges in the clk domain, and at each frame boundary
// advances the horizontal scroll offset and frame counter. At the same point
// it applies a single buffered run/pause/stop/set command, so no frame tears.
//
// Ports:
//   clk, reset        pixel clock, asynchronous active-high reset
//   vsync             level vsync, synchronous to clk
//   cfg_valid/_data   config word {cmd[1:0], speed[2:0], dir, pattern[1:0]}
//   cfg_ready         high while the one-entry config buffer is empty
//   x_offset          scroll offset (mod 1024)
//   pattern_sel       colour pattern selector
//   frame_no          9-bit wrapping frame counter
//   frame_tick        one-cycle pulse per frame boundary
//   running           high while in RUNNING
//
// Optional feature: define AUTO_CYCLE_EN to step pattern_sel automatically
// every CYCLE_FRAMES boundaries while RUNNING. CYCLE_FRAMES has a legal
// range of 1..1023.
module vga_scroll_sequencer #(
  parameter int CYCLE_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  output logic [9:0] x_offset,
  output logic [1:0] pattern_sel,
  output logic [8:0] frame_no,
  output logic       frame_tick,
  output logic       running
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  localparam logic [1:0] CMD_SET   = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_PAUSE = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  state_t      state_q, state_d;
  logic        prev_vsync_q, prev_vsync_d;
  logic        buf_full_q, buf_full_d;
  logic [7:0]  buf_dat_q, buf_dat_d;
  logic        cfg_ready_q, cfg_ready_d;
  logic [2:0]  speed_q, speed_d;
  logic        dir_q, dir_d;
  logic [9:0]  x_offset_q, x_offset_d;
  logic [1:0]  pattern_q, pattern_d;
  logic [8:0]  frame_no_q, frame_no_d;
  logic        tick_q, tick_d;
  logic        running_q, running_d;

  logic        boundary;
  logic        accept;
  logic        apply;
  logic [1:0]  buf_cmd;
  logic        load_fields;

  // prev_vsync resets high so a vsync already high at reset release does
  // not produce a spurious boundary.
  assign boundary    = vsync & ~prev_vsync_q;
  assign accept      = cfg_valid & cfg_ready_q;
  // Only a word already sitting in the buffer is applied; a word accepted on
  // the boundary edge itself lands in the buffer and waits a frame.
  assign apply       = boundary & buf_full_q;
  assign buf_cmd     = buf_dat_q[7:6];
  assign load_fields = apply & ((buf_cmd == CMD_SET) | (buf_cmd == CMD_RUN));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: state only moves when a buffered command is applied.
  always_comb begin
    state_d = state_q;
    if (apply) begin
      case (buf_cmd)
        CMD_RUN:   state_d = ST_RUNNING;
        CMD_PAUSE: state_d = ST_PAUSED;
        CMD_STOP:  state_d = ST_STOPPED;
        default:   state_d = state_q;
      endcase
    end
  end

`ifdef AUTO_CYCLE_EN
  localparam logic [9:0] CYCLE_LIM = 10'(CYCLE_FRAMES);
  logic [9:0] cyc_cnt_q, cyc_cnt_d;
  logic       auto_step;
`endif

  // Output / datapath next values.
  always_comb begin
    prev_vsync_d = vsync;
    tick_d       = boundary;
    buf_full_d   = buf_full_q;
    buf_dat_d    = buf_dat_q;
    speed_d      = speed_q;
    dir_d        = dir_q;
    pattern_d    = pattern_q;
    frame_no_d   = frame_no_q;
    x_offset_d   = x_offset_q;

    // Buffer: applying empties it; accepting (only possible when empty) fills.
    if (apply) begin
      buf_full_d = 1'b0;
    end
    if (accept) begin
      buf_full_d = 1'b1;
      buf_dat_d  = cfg_data;
    end

    if (load_fields) begin
      speed_d   = buf_dat_q[5:3];
      dir_d     = buf_dat_q[2];
      pattern_d = buf_dat_q[1:0];
    end

    if (boundary) begin
      frame_no_d = frame_no_q + 9'd1;
      // The state action uses the freshly applied speed/dir.
      if (state_d == ST_RUNNING) begin
        if (dir_d) begin
          x_offset_d = x_offset_q - {7'd0, speed_d};
        end else begin
          x_offset_d = x_offset_q + {7'd0, speed_d};
        end
      end
    end

    if (state_d == ST_STOPPED) begin
      x_offset_d = 10'd0;
    end

`ifdef AUTO_CYCLE_EN
    // Applied config clears the count and suppresses the step, so its
    // pattern wins over a coinciding auto step.
    cyc_cnt_d = cyc_cnt_q;
    auto_step = 1'b0;
    if (boundary) begin
      if (load_fields || (state_d != ST_RUNNING)) begin
        cyc_cnt_d = 10'd0;
      end else if ((cyc_cnt_q + 10'd1) == CYCLE_LIM) begin
        cyc_cnt_d = 10'd0;
        auto_step = 1'b1;
      end else begin
        cyc_cnt_d = cyc_cnt_q + 10'd1;
      end
    end
    if (auto_step) begin
      pattern_d = pattern_q + 2'd1;
    end
`endif

    running_d   = (state_d == ST_RUNNING);
    cfg_ready_d = ~buf_full_d;
  end

  // Datapath / output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_vsync_q <= 1'b1;
      buf_full_q   <= 1'b0;
      buf_dat_q    <= 8'd0;
      cfg_ready_q  <= 1'b1;
      speed_q      <= 3'd1;
      dir_q        <= 1'b0;
      x_offset_q   <= 10'd0;
      pattern_q    <= 2'd0;
      frame_no_q   <= 9'd0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      prev_vsync_q <= prev_vsync_d;
      buf_full_q   <= buf_full_d;
      buf_dat_q    <= buf_dat_d;
      cfg_ready_q  <= cfg_ready_d;
      speed_q      <= speed_d;
      dir_q        <= dir_d;
      x_offset_q   <= x_offset_d;
      pattern_q    <= pattern_d;
      frame_no_q   <= frame_no_d;
      tick_q       <= tick_d;
      running_q    <= running_d;
    end
  end

`ifdef AUTO_CYCLE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt_q <= 10'd0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end
`endif

  assign cfg_ready   = cfg_ready_q;
  assign x_offset    = x_offset_q;
  assign pattern_sel = pattern_q;
  assign frame_no    = frame_no_q;
  assign frame_tick  = tick_q;
  assign running     = running_q;

endmodule
